// File: rtl/fir.sv
// fir: Tape_Num-tap FIR filter. Taps and control are set over AXI-Lite, samples
// arrive and results leave on AXI-Stream, and taps and samples sit in external
// single-port RAMs (byte address, one cycle read latency).
// Optional feature: define FIR_SM_TLAST_EN to raise sm_tlast with the final output.
module fir #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int Tape_Num    = 11
) (
    output logic                   awready,
    output logic                   wready,
    input  logic                   awvalid,
    input  logic [pADDR_WIDTH-1:0] awaddr,
    input  logic                   wvalid,
    input  logic [pDATA_WIDTH-1:0] wdata,
    output logic                   arready,
    input  logic                   rready,
    input  logic                   arvalid,
    input  logic [pADDR_WIDTH-1:0] araddr,
    output logic                   rvalid,
    output logic [pDATA_WIDTH-1:0] rdata,
    input  logic                   ss_tvalid,
    input  logic [pDATA_WIDTH-1:0] ss_tdata,
    input  logic                   ss_tlast,
    output logic                   ss_tready,
    input  logic                   sm_tready,
    output logic                   sm_tvalid,
    output logic [pDATA_WIDTH-1:0] sm_tdata,
    output logic                   sm_tlast,
    output logic [3:0]             tap_WE,
    output logic                   tap_EN,
    output logic [pDATA_WIDTH-1:0] tap_Di,
    output logic [pADDR_WIDTH-1:0] tap_A,
    input  logic [pDATA_WIDTH-1:0] tap_Do,
    output logic [3:0]             data_WE,
    output logic                   data_EN,
    output logic [pDATA_WIDTH-1:0] data_Di,
    output logic [pADDR_WIDTH-1:0] data_A,
    input  logic [pDATA_WIDTH-1:0] data_Do,
    input  logic                   axis_clk,
    input  logic                   axis_rst_n
);
    localparam int CNT_W = $clog2(Tape_Num + 1);
    localparam logic [CNT_W-1:0] LAST_K  = CNT_W'(Tape_Num - 1);
    localparam logic [CNT_W-1:0] DRAIN_K = CNT_W'(Tape_Num);
    localparam logic [pADDR_WIDTH-1:0] ADDR_CTRL    = '0;
    localparam logic [pADDR_WIDTH-1:0] ADDR_LEN     = pADDR_WIDTH'(32'h10);
    localparam logic [pADDR_WIDTH-1:0] ADDR_TAP     = pADDR_WIDTH'(32'h20);
    localparam logic [pADDR_WIDTH-1:0] ADDR_TAP_END = pADDR_WIDTH'(32'h20 + 4 * Tape_Num);

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_WAIT_IN, S_MAC, S_OUT, S_DONE} state_t;
    state_t state, state_nxt;

    // Multiply-accumulate in a W-bit context keeps only the low bits: two's-complement wrap.
    function automatic logic signed [pDATA_WIDTH-1:0] wrap_mac(
        input logic signed [pDATA_WIDTH-1:0] acc,
        input logic signed [pDATA_WIDTH-1:0] h,
        input logic signed [pDATA_WIDTH-1:0] x);
        return acc + h * x;
    endfunction

    function automatic logic in_tap_range(input logic [pADDR_WIDTH-1:0] a);
        return (a >= ADDR_TAP) && (a < ADDR_TAP_END);
    endfunction

    function automatic logic [pADDR_WIDTH-1:0] word_addr(input logic [CNT_W-1:0] k);
        return pADDR_WIDTH'({k, 2'b00});
    endfunction

    logic                          ap_start, ap_done, ap_idle;
    logic [pDATA_WIDTH-1:0]        data_length;
    logic [pADDR_WIDTH-1:0]        rd_addr;
    logic                          rd_tap_ok, rd_first;
    logic [pDATA_WIDTH-1:0]        rdata_q, rdata_live;
    logic [CNT_W-1:0]              mac_cnt, ptr, rd_idx;
    logic [pDATA_WIDTH-1:0]        out_cnt;
    logic                          vld_p0, vld_p1;
    logic signed [pDATA_WIDTH-1:0] acc_p1;
    logic                          wr_fire, wr_tap, rd_fire, in_fire, out_fire, last_out;
    logic                          unused_ok;

    assign unused_ok = ss_tlast;
    assign wready    = awready;
    assign wr_fire   = awready & awvalid & wvalid;
    assign wr_tap    = wr_fire & in_tap_range(awaddr);
    assign rd_fire   = arready & arvalid;
    assign in_fire   = ss_tvalid & ss_tready;
    assign out_fire  = sm_tvalid & sm_tready;
    assign last_out  = (out_cnt + 1'b1) == data_length;
    assign vld_p0    = (state == S_MAC) && (mac_cnt <= LAST_K);

    // AXI-Lite handshakes: one-cycle ready pulses, read data held until rready.
    always_ff @(posedge axis_clk or posedge axis_rst_n) begin
        if (axis_rst_n) begin
            awready   <= 1'b0;
            arready   <= 1'b0;
            rvalid    <= 1'b0;
            rd_first  <= 1'b0;
            rd_addr   <= '0;
            rd_tap_ok <= 1'b0;
            rdata_q   <= '0;
        end else begin
            awready  <= awvalid & wvalid & ~awready;
            arready  <= arvalid & ~arready & ~rvalid;
            rd_first <= rd_fire;
            if (rd_fire) begin
                rd_addr   <= araddr;
                rd_tap_ok <= ap_idle & in_tap_range(araddr);
            end
            if (rd_fire)
                rvalid <= 1'b1;
            else if (rvalid && rready)
                rvalid <= 1'b0;
            if (rd_first)
                rdata_q <= rdata_live;
        end
    end

    // Read mux; the first rvalid cycle shows live RAM data, later cycles the captured copy.
    always_comb begin
        rdata_live = '0;
        if (rd_addr == ADDR_CTRL)
            rdata_live = pDATA_WIDTH'({ap_idle, ap_done, ap_start});
        else if (rd_addr == ADDR_LEN)
            rdata_live = data_length;
        else if (rd_tap_ok)
            rdata_live = tap_Do;
    end

    assign rdata = rvalid ? (rd_first ? rdata_live : rdata_q) : '0;

    // Control register file: start pulse, done/idle flags, output count target.
    always_ff @(posedge axis_clk or posedge axis_rst_n) begin
        if (axis_rst_n) begin
            ap_start    <= 1'b0;
            ap_done     <= 1'b0;
            ap_idle     <= 1'b1;
            data_length <= '0;
        end else begin
            ap_start <= 1'b0;
            if (wr_fire && awaddr == ADDR_LEN)
                data_length <= wdata;
            if (wr_fire && awaddr == ADDR_CTRL && wdata[0] && ap_idle) begin
                ap_start <= 1'b1;
                ap_idle  <= 1'b0;
                ap_done  <= 1'b0;
            end else if (state == S_DONE) begin
                ap_done <= 1'b1;
                ap_idle <= 1'b1;
            end
        end
    end

    // Tap RAM owner: the MAC while filtering, otherwise AXI-Lite (only when idle).
    always_comb begin
        tap_EN = 1'b0;
        tap_WE = 4'h0;
        tap_A  = '0;
        tap_Di = '0;
        if (vld_p0) begin
            tap_EN = 1'b1;
            tap_A  = word_addr(mac_cnt);
        end else if (ap_idle && wr_tap) begin
            tap_EN = 1'b1;
            tap_WE = 4'hF;
            tap_A  = awaddr - ADDR_TAP;
            tap_Di = wdata;
        end else if (ap_idle && rd_fire && in_tap_range(araddr)) begin
            tap_EN = 1'b1;
            tap_A  = araddr - ADDR_TAP;
        end
    end

    // FSM state register.
    always_ff @(posedge axis_clk or posedge axis_rst_n) begin
        if (axis_rst_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // FSM next state plus stream handshakes and sample RAM port.
    always_comb begin
        state_nxt = state;
        ss_tready = 1'b0;
        sm_tvalid = 1'b0;
        data_EN   = 1'b0;
        data_WE   = 4'h0;
        data_A    = '0;
        data_Di   = '0;
        case (state)
            S_IDLE: if (ap_start) state_nxt = S_CLEAR;
            S_CLEAR: begin
                data_EN = 1'b1;
                data_WE = 4'hF;
                data_A  = word_addr(mac_cnt);
                if (mac_cnt == LAST_K) state_nxt = S_WAIT_IN;
            end
            S_WAIT_IN: begin
                ss_tready = ss_tvalid;
                if (ss_tvalid) begin
                    data_EN   = 1'b1;
                    data_WE   = 4'hF;
                    data_A    = word_addr(ptr);
                    data_Di   = ss_tdata;
                    state_nxt = S_MAC;
                end
            end
            S_MAC: begin
                if (vld_p0) begin
                    data_EN = 1'b1;
                    data_A  = word_addr(rd_idx);
                end
                if (mac_cnt == DRAIN_K) state_nxt = S_OUT;
            end
            S_OUT: begin
                sm_tvalid = 1'b1;
                if (sm_tready) state_nxt = last_out ? S_DONE : S_WAIT_IN;
            end
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Sequencing counters: clear index / tap index, circular write pointer, output count.
    always_ff @(posedge axis_clk or posedge axis_rst_n) begin
        if (axis_rst_n) begin
            mac_cnt <= '0;
            ptr     <= '0;
            rd_idx  <= '0;
            out_cnt <= '0;
            vld_p1  <= 1'b0;
        end else begin
            vld_p1 <= vld_p0;
            case (state)
                S_IDLE: if (ap_start) begin
                    mac_cnt <= '0;
                    ptr     <= '0;
                    out_cnt <= '0;
                end
                S_CLEAR: mac_cnt <= (mac_cnt == LAST_K) ? '0 : mac_cnt + 1'b1;
                S_WAIT_IN: if (in_fire) begin
                    rd_idx  <= ptr;
                    ptr     <= (ptr == LAST_K) ? '0 : ptr + 1'b1;
                    mac_cnt <= '0;
                end
                S_MAC: begin
                    mac_cnt <= mac_cnt + 1'b1;
                    if (vld_p0) rd_idx <= (rd_idx == '0) ? LAST_K : rd_idx - 1'b1;
                end
                S_OUT: if (out_fire) out_cnt <= out_cnt + 1'b1;
                default: ;
            endcase
        end
    end

    // Stage p1: RAM words arrive one cycle after issue and are accumulated.
    always_ff @(posedge axis_clk) begin
        if (in_fire)
            acc_p1 <= '0;
        else if (vld_p1)
            acc_p1 <= wrap_mac(acc_p1, tap_Do, data_Do);
    end

    // Stage p2: final product folded in and result held for the output stream.
    always_ff @(posedge axis_clk or posedge axis_rst_n) begin
        if (axis_rst_n)
            sm_tdata <= '0;
        else if (state == S_MAC && mac_cnt == DRAIN_K)
            sm_tdata <= wrap_mac(acc_p1, tap_Do, data_Do);
    end

`ifdef FIR_SM_TLAST_EN
    assign sm_tlast = (state == S_OUT) && last_out;
`else
    assign sm_tlast = 1'b0;
`endif

endmodule

// File: tb/tb_fir.sv
// tb_fir: randomized scoreboard bench for fir with behavioural RAM models and a
// direct-convolution reference.
module tb_fir;
    localparam int AW = 12;
    localparam int DW = 32;
    localparam int NT = 11;

    logic          axis_clk = 1'b0;
    logic          axis_rst_n;
    logic          awready, wready, awvalid, wvalid;
    logic [AW-1:0] awaddr, araddr;
    logic [DW-1:0] wdata, rdata;
    logic          arready, rready, arvalid, rvalid;
    logic          ss_tvalid, ss_tlast, ss_tready;
    logic [DW-1:0] ss_tdata;
    logic          sm_tready, sm_tvalid, sm_tlast;
    logic [DW-1:0] sm_tdata;
    logic [3:0]    tap_WE, data_WE;
    logic          tap_EN, data_EN;
    logic [DW-1:0] tap_Di, tap_Do, data_Di, data_Do;
    logic [AW-1:0] tap_A, data_A;

    always #5 axis_clk = ~axis_clk;

    fir #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW), .Tape_Num(NT)) dut (
        .awready(awready), .wready(wready), .awvalid(awvalid), .awaddr(awaddr),
        .wvalid(wvalid), .wdata(wdata),
        .arready(arready), .rready(rready), .arvalid(arvalid), .araddr(araddr),
        .rvalid(rvalid), .rdata(rdata),
        .ss_tvalid(ss_tvalid), .ss_tdata(ss_tdata), .ss_tlast(ss_tlast), .ss_tready(ss_tready),
        .sm_tready(sm_tready), .sm_tvalid(sm_tvalid), .sm_tdata(sm_tdata), .sm_tlast(sm_tlast),
        .tap_WE(tap_WE), .tap_EN(tap_EN), .tap_Di(tap_Di), .tap_A(tap_A), .tap_Do(tap_Do),
        .data_WE(data_WE), .data_EN(data_EN), .data_Di(data_Di), .data_A(data_A), .data_Do(data_Do),
        .axis_clk(axis_clk), .axis_rst_n(axis_rst_n)
    );

    // External RAM models: word k at byte address 4k, registered read
    logic [DW-1:0] tap_mem  [0:NT-1];
    logic [DW-1:0] data_mem [0:NT-1];

    function automatic int widx(input logic [AW-1:0] a);
        return int'(a >> 2);
    endfunction

    initial begin
        for (int i = 0; i < NT; i++) begin
            tap_mem[i]  <= '0;
            data_mem[i] <= 32'h5A5A_0000 + 32'(i * 7919 + 13);
        end
    end

    always @(posedge axis_clk) begin
        if (tap_EN) begin
            if (widx(tap_A) < NT) begin
                tap_Do <= tap_mem[widx(tap_A)];
                if (tap_WE == 4'hF) tap_mem[widx(tap_A)] <= tap_Di;
            end else tap_Do <= '0;
        end
        if (data_EN) begin
            if (widx(data_A) < NT) begin
                data_Do <= data_mem[widx(data_A)];
                if (data_WE == 4'hF) data_mem[widx(data_A)] <= data_Di;
            end else data_Do <= '0;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h (%0d), expected 0x%08h (%0d)",
                     name, act, $signed(act), exp, $signed(exp));
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // Reference model: direct convolution over the samples of the current run
    typedef struct {logic [31:0] data; logic last;} exp_t;
    exp_t exp_q[$];
    int   hist[$];
    int   taps[NT];
    int   run_len;
    int   spec_taps[NT] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};

    function automatic logic [31:0] model_y();
        longint acc = 0;
        int n = hist.size();
        for (int k = 0; k < NT; k++)
            if (n - 1 - k >= 0) acc += longint'(taps[k]) * longint'(hist[n - 1 - k]);
        return acc[31:0];
    endfunction

    task automatic axi_write(input logic [AW-1:0] addr, input logic [31:0] data);
        bit ok = 0;
        @(negedge axis_clk);
        awvalid = 1'b1; wvalid = 1'b1; awaddr = addr; wdata = data;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge axis_clk);
            if (awready && wready) ok = 1;
        end
        if (ok) begin
            @(posedge axis_clk); #1;
        end else timeout_fail("axi_write");
        awvalid = 1'b0; wvalid = 1'b0;
    endtask

    task automatic axi_read(input logic [AW-1:0] addr, output logic [31:0] data);
        bit ok = 0;
        data = 'x;
        @(negedge axis_clk);
        arvalid = 1'b1; araddr = addr;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge axis_clk);
            if (arready) ok = 1;
        end
        if (!ok) begin
            timeout_fail("axi_read_arready");
            arvalid = 1'b0;
            return;
        end
        @(posedge axis_clk); #1;
        arvalid = 1'b0;
        ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge axis_clk);
            if (rvalid) ok = 1;
        end
        if (!ok) begin
            timeout_fail("axi_read_rvalid");
            return;
        end
        data = rdata;
        rready = 1'b1;
        @(posedge axis_clk); #1;
        rready = 1'b0;
    endtask

    task automatic send_sample(input int x);
        exp_t e;
        bit ok = 0;
        hist.push_back(x);
        e.data = model_y();
        e.last = (hist.size() == run_len);
        exp_q.push_back(e);
        @(negedge axis_clk);
        ss_tvalid = 1'b1; ss_tdata = x; ss_tlast = e.last;
        for (int i = 0; i < 3000 && !ok; i++) begin
            #1;
            if (ss_tready) ok = 1;
            else @(negedge axis_clk);
        end
        if (ok) begin
            @(posedge axis_clk); #1;
        end else timeout_fail("ss_tready");
        ss_tvalid = 1'b0; ss_tlast = 1'b0;
    endtask

    task automatic start_run(input int len);
        run_len = len;
        hist.delete();
        axi_write(12'h10, 32'(len));
        axi_write(12'h00, 32'h1);
    endtask

    task automatic finish_run(input string name);
        logic [31:0] v;
        bit ok = 0;
        for (int i = 0; i < 20000 && exp_q.size() != 0; i++) @(negedge axis_clk);
        if (exp_q.size() != 0) timeout_fail({name, "_outputs"});
        for (int i = 0; i < 40 && !ok; i++) begin
            axi_read(12'h00, v);
            if (v[1]) ok = 1;
        end
        check({name, "_ctrl_done"}, v, 32'h6);
    endtask

    // Output backpressure: 0 always ready, 1 random, 2 five stalled cycles per output
    int bp_mode = 0;
    initial begin
        int stall = 0;
        sm_tready = 1'b0;
        forever begin
            @(posedge axis_clk); #2;
            case (bp_mode)
                0: sm_tready = 1'b1;
                1: sm_tready = ($urandom_range(0, 3) != 0);
                default: begin
                    if (sm_tvalid) begin
                        stall++;
                        sm_tready = (stall > 5);
                    end else begin
                        stall = 0;
                        sm_tready = 1'b0;
                    end
                end
            endcase
        end
    end

    // Monitor: pops the scoreboard on each transfer and checks held data while stalled
    initial begin
        exp_t        e;
        logic        held_vld = 1'b0;
        logic [31:0] held;
        forever begin
            @(negedge axis_clk);
            if (!axis_rst_n && sm_tvalid) begin
                if (held_vld) check("sm_tdata_stable", sm_tdata, held);
                if (sm_tready) begin
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_output: got 0x%08h, expected no output", sm_tdata);
                    end else begin
                        e = exp_q.pop_front();
                        check("y", sm_tdata, e.data);
`ifdef FIR_SM_TLAST_EN
                        check("sm_tlast", 32'(sm_tlast), 32'(e.last));
`else
                        check("sm_tlast", 32'(sm_tlast), 32'h0);
`endif
                    end
                    held_vld = 1'b0;
                end else begin
                    held_vld = 1'b1;
                    held     = sm_tdata;
                    check("ss_tready_during_out", 32'(ss_tready), 32'h0);
                end
            end else held_vld = 1'b0;
        end
    end

    initial begin
        logic [31:0] v, v1, v2;
        awvalid = 0; wvalid = 0; awaddr = '0; wdata = '0;
        arvalid = 0; araddr = '0; rready = 0;
        ss_tvalid = 0; ss_tdata = '0; ss_tlast = 0;
        axis_rst_n = 1'b1;
        repeat (3) @(negedge axis_clk);
        check("rst_awready", 32'(awready), 0);
        check("rst_arready", 32'(arready), 0);
        check("rst_rvalid", 32'(rvalid), 0);
        check("rst_rdata", rdata, 0);
        check("rst_ss_tready", 32'(ss_tready), 0);
        check("rst_sm_tvalid", 32'(sm_tvalid), 0);
        check("rst_sm_tdata", sm_tdata, 0);
        check("rst_sm_tlast", 32'(sm_tlast), 0);
        check("rst_ram_en", {30'b0, tap_EN, data_EN}, 0);
        check("rst_ram_we", {24'b0, tap_WE, data_WE}, 0);
        axis_rst_n = 1'b0;
        axi_read(12'h00, v);
        check("ctrl_after_reset", v, 32'h4);
        axi_read(12'h10, v);
        check("len_after_reset", v, 32'h0);

        // Input offered before ap_start must stall
        @(negedge axis_clk);
        ss_tvalid = 1'b1; ss_tdata = 32'd77;
        repeat (4) begin
            @(negedge axis_clk);
            check("ss_tready_before_start", 32'(ss_tready), 0);
        end
        ss_tvalid = 1'b0;

        for (int k = 0; k < NT; k++) begin
            axi_write(12'(32'h20 + 4 * k), spec_taps[k]);
            taps[k] = spec_taps[k];
        end
        for (int k = 0; k < NT; k++) begin
            axi_read(12'(32'h20 + 4 * k), v);
            check($sformatf("tap_rd%0d", k), v, spec_taps[k]);
        end

        // Impulse response with concurrent AXI-Lite traffic mid-run
        bp_mode = 0;
        start_run(11);
        fork
            begin
                for (int i = 0; i < 11; i++) send_sample(i == 0 ? 1 : 0);
            end
            begin
                repeat (30) @(negedge axis_clk);
                axi_read(12'h00, v1);
                check("ctrl_busy", v1, 32'h0);
                axi_read(12'h24, v2);
                check("tap_read_busy", v2, 32'h0);
                axi_write(12'h24, 32'd999);
            end
        join
        finish_run("impulse");
        axi_read(12'h24, v);
        check("tap_write_ignored_busy", v, 32'hFFFF_FFF6);
        axi_read(12'h10, v);
        check("len_readback", v, 32'd11);

        // Step response with five stalled cycles on every output
        bp_mode = 2;
        start_run(11);
        for (int i = 0; i < 11; i++) send_sample(1);
        finish_run("step");

        // Abort mid-MAC with reset, then rerun the impulse
        bp_mode = 0;
        start_run(11);
        for (int i = 0; i < 3; i++) send_sample(int'($urandom()));
        repeat (4) @(negedge axis_clk);
        axis_rst_n = 1'b1;
        exp_q.delete();
        hist.delete();
        @(negedge axis_clk);
        check("midrst_sm_tvalid", 32'(sm_tvalid), 0);
        check("midrst_ss_tready", 32'(ss_tready), 0);
        @(negedge axis_clk);
        axis_rst_n = 1'b0;
        axi_read(12'h00, v);
        check("ctrl_after_abort", v, 32'h4);
        start_run(11);
        for (int i = 0; i < 11; i++) send_sample(i == 0 ? 1 : 0);
        finish_run("impulse_rerun");

        // Random taps and samples, longer than the tap window, random backpressure
        for (int k = 0; k < NT; k++) begin
            taps[k] = int'($urandom());
            axi_write(12'(32'h20 + 4 * k), taps[k]);
        end
        bp_mode = 1;
        start_run(15);
        for (int i = 0; i < 15; i++) begin
            if (i % 3 == 0) send_sample(int'($urandom()));
            else send_sample(int'($urandom_range(0, 200)) - 100);
        end
        finish_run("random");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/fir.md
FIR -- requirements
Module: fir

Interface
REQ-001 axis_clk  in  1  sole clock; all state updates on rising edge.
REQ-002 axis_rst_n  in  1  asynchronous, active-high reset; 1 = in reset, despite the suffix.
REQ-003 pADDR_WIDTH, default 12, AXI-Lite and RAM address width.
REQ-004 pDATA_WIDTH, default 32, data width.
REQ-005 Tape_Num, default 11, number of taps.
REQ-006 AXI-Lite write: awvalid in 1; awaddr in 12; awready out 1; wvalid in 1; wdata in 32; wready out 1.
REQ-007 AXI-Lite read: arvalid in 1; araddr in 12; arready out 1; rready in 1; rvalid out 1; rdata out 32.
REQ-008 Input stream: ss_tvalid in 1; ss_tdata in 32 signed; ss_tlast in 1; ss_tready out 1.
REQ-009 Output stream: sm_tready in 1; sm_tvalid out 1; sm_tdata out 32 signed; sm_tlast out 1.
REQ-010 tap_WE out 4, tap_EN out 1, tap_Di out 32, tap_A out 12, tap_Do in 32: external 11-word tap RAM.
REQ-011 data_WE, data_EN, data_Di, data_A, data_Do: same widths, external 11-word sample RAM.
REQ-012 Both RAMs: byte address (word k at 4k); WE=4'hF writes Di at the clock edge; Do valid one cycle after address.

Function
REQ-013 Address map: 0x00 ap_ctrl (bit0 ap_start, bit1 ap_done, bit2 ap_idle); 0x10 data_length; 0x20+4k, k=0..10, tap k.
REQ-014 Write: when awvalid&wvalid, pulse awready and wready together for one cycle and commit the write.
REQ-015 Read: when arvalid, pulse arready; present rvalid with rdata on the next cycle and hold until rready.
REQ-016 Tap write: tap_EN=1, tap_WE=4'hF, tap_A=awaddr-0x20, tap_Di=wdata; a tap read returns tap_Do.
REQ-017 While not idle: tap writes are acknowledged but ignored; tap reads return 0.
REQ-018 Writing bit0=1 to 0x00 while idle sets ap_start for exactly one cycle.
REQ-019 ap_start clears ap_idle and ap_done and starts processing.
REQ-020 States: IDLE -> CLEAR (11 cycles, write 0 to data RAM words 0..10) -> WAIT_IN -> MAC (11 taps) -> OUT -> WAIT_IN, or -> DONE -> IDLE.
REQ-021 ss_tready is 0 outside WAIT_IN; inputs offered before ap_start stall.
REQ-022 In WAIT_IN with ss_tvalid, pulse ss_tready and write the sample to data RAM at a circular pointer (0..10, wraps at 10).
REQ-023 MAC: y[n] = sum over k=0..10 of h[k]*x[n-k], with x before the first sample = 0; signed 32x32 products.
REQ-024 The accumulator keeps the low 32 bits (two's-complement wrap).
REQ-025 RAM read latency of 1 cycle is pipelined into the MAC.
REQ-026 OUT: hold sm_tvalid and sm_tdata stable until sm_tready; the transfer occurs on the cycle both are high.
REQ-027 After data_length outputs transfer: ap_done=1, ap_idle=1; both hold until the next ap_start.
REQ-028 0x00 read returns {29'b0, ap_idle, ap_done, ap_start}; 0x10 reads back data_length; reads have no side effects.
REQ-029 A simultaneous AXI-Lite access and stream activity do not interfere.

Reset
REQ-030 While axis_rst_n=1, all outputs are 0 except ap_idle=1: handshakes, sm_tvalid, sm_tdata, RAM enables/WE, ap_done, ap_start, pointer, data_length.
REQ-031 Reset mid-operation aborts at once to IDLE; tap RAM contents are preserved.

Configuration
REQ-032 FIR_SM_TLAST_EN defined: sm_tlast=1 with the final (data_length-th) output only.
REQ-033 FIR_SM_TLAST_EN undefined: sm_tlast tied to 0; everything else unchanged.

Verification
REQ-034 Write taps {0,-10,-9,23,56,63,56,23,-9,-10,0} -> each read of 0x20..0x48 returns the same values.
REQ-035 data_length=11, ap_start, input impulse 1,0x10 -> outputs 0,-10,-9,23,56,63,56,23,-9,-10,0.
REQ-036 Eleven inputs of 1 -> outputs 0,-10,-19,4,60,123,179,202,193,183,183.
REQ-037 Stream in mid-run, read 0x00 -> bit2=0; after last output, 0x00 -> bit1=1 and bit2=1; sm_tlast on last output only (macro defined).
REQ-038 Hold sm_tready=0 for 5 cycles during OUT -> sm_tdata stable, no sample lost, ss_tready stays 0.
REQ-039 Assert reset mid-MAC, then rerun the impulse test -> identical results (data RAM re-cleared).
